// File: rtl/wb_sram_sp_initiator_pkg.sv
// wb_sram_sp_initiator_pkg
//   Shared definitions for the Wishbone-to-SRAM initiator:
//   - Wishbone B3 cycle type (CTI) and burst type extension (BTE) codes
//   - FSM state encoding
//   - clog2 helper used to derive the word-index shift from the data width
package wb_sram_sp_initiator_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    BURST = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_sram_sp_initiator_if.sv
// wb_sram_sp_initiator_if
//   Wishbone B3 bus bundle between the tile bus master and the SRAM
//   initiator. Signal names keep the slave-side _i/_o view.
//   Parameters: AW address width (bytes), DW data width.
//   Modports:
//     master : drives adr/dat/sel/we/cyc/stb/cti/bte, samples ack/err/dat_o
//     slave  : the reverse (used by wb_sram_sp_initiator)
interface wb_sram_sp_initiator_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [SW-1:0] wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic [DW-1:0] wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
           wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i,
           wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_err_o, wb_dat_o
  );

endinterface

// File: rtl/wb_sram_sp_initiator_adr_next.sv
// wb_burst_adr_next
//   Combinational next-beat address for Wishbone incrementing bursts.
//   The word index (adr >> log2(DW/8)) is incremented by one:
//     bte 00 : linear, full-width add, wraps at 2^AW
//     bte 01 : only the low 2 index bits count (wrap-4)
//     bte 10 : only the low 3 index bits count (wrap-8)
//     bte 11 : only the low 4 index bits count (wrap-16)
//   Byte-offset bits below the word index pass through unchanged.
//   Ports: adr (current byte address), bte, adr_next (result).
module wb_burst_adr_next
  import wb_sram_sp_initiator_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0] adr,
  input  logic [1:0]    bte,
  output logic [AW-1:0] adr_next
);

  localparam int SW  = DW / 8;
  localparam int LSB = clog2(SW);

  logic [AW-1:0] idx;
  logic [AW-1:0] idx_inc;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] idx_next;
  logic [AW-1:0] byte_mask;

  assign idx       = adr >> LSB;
  assign idx_inc   = idx + AW'(1);
  assign byte_mask = (AW'(1) << LSB) - AW'(1);

  always_comb begin
    wrap_mask = '1;
    case (bte)
      BTE_WRAP4:  wrap_mask = AW'(3);
      BTE_WRAP8:  wrap_mask = AW'(7);
      BTE_WRAP16: wrap_mask = AW'(15);
      default:    wrap_mask = '1;
    endcase
  end

  // Counting bits come from the incremented index, held bits from the original.
  assign idx_next = (idx & ~wrap_mask) | (idx_inc & wrap_mask);

  // In linear mode the carry out of the top index bit falls off the
  // left edge after the shift, giving the 2^AW wrap.
  assign adr_next = (idx_next << LSB) | (adr & byte_mask);

endmodule

// File: rtl/wb_sram_sp_initiator.sv
// wb_sram_sp_initiator
//   Wishbone B3 slave that drives a single-port, byte-select synchronous
//   SRAM with one cycle of read latency.
//   - Classic cycles and all writes: issue in IDLE, ack in ACK (2 cycles/beat).
//   - Incrementing read bursts (cti=010): first read issued in IDLE, then
//     one read per cycle from BURST while the previous read is acked,
//     giving 1 beat per cycle.
//   - SRAM outputs and wb_ack_o/wb_err_o are combinational from the
//     registered state; everything is forced to 0 while rst is high.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     wb                : Wishbone slave modport
//     sram_ce/we/oe     : SRAM chip/write/output enable
//     sram_addr         : SRAM byte address
//     sram_din/sram_sel : SRAM write data and byte selects
//     sram_dout         : SRAM read data, valid one cycle after issue
//   Optional feature (macro WB_SRAM_INITIATOR_ADDR_CHECK_EN):
//     accesses at or beyond MEM_SIZE issue nothing and are answered with
//     wb_err_o. Without the macro wb_err_o is tied low and addresses alias.
module wb_sram_sp_initiator
  import wb_sram_sp_initiator_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int unsigned MEM_SIZE = 32'h8000
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_sram_sp_initiator_if.slave wb,
  output logic                 sram_ce,
  output logic                 sram_we,
  output logic                 sram_oe,
  output logic [AW-1:0]        sram_addr,
  output logic [DW-1:0]        sram_din,
  output logic [DW/8-1:0]      sram_sel,
  input  logic [DW-1:0]        sram_dout
);

  localparam int SW = DW / 8;

  state_t        state;
  logic [AW-1:0] burst_adr;
  logic [AW-1:0] next_src;
  logic [AW-1:0] next_adr;
  logic          req;
  logic          adr_ok;
  logic          burst_ok;
  logic          err_pend;
  logic          start_burst;

  assign req         = wb.wb_cyc_i & wb.wb_stb_i;
  assign start_burst = ~wb.wb_we_i & (wb.wb_cti_i == CTI_INCR);

`ifdef WB_SRAM_INITIATOR_ADDR_CHECK_EN
  localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_SIZE);
  assign adr_ok   = {1'b0, wb.wb_adr_i} < MEM_LIMIT;
  assign burst_ok = {1'b0, burst_adr} < MEM_LIMIT;
`else
  logic [31:0] unused_mem_size;
  assign unused_mem_size = 32'(MEM_SIZE);
  assign adr_ok   = 1'b1;
  assign burst_ok = 1'b1;
  assign err_pend = 1'b0;
`endif

  // One calculator serves both the burst start (from the bus address)
  // and the running burst (from the held burst address).
  assign next_src = (state == IDLE) ? wb.wb_adr_i : burst_adr;

  wb_burst_adr_next #(
    .AW (AW),
    .DW (DW)
  ) u_adr_next (
    .adr      (next_src),
    .bte      (wb.wb_bte_i),
    .adr_next (next_adr)
  );

  // Read data is passed straight through; it is only meaningful on ack.
  assign wb.wb_dat_o = sram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_adr <= '0;
`ifdef WB_SRAM_INITIATOR_ADDR_CHECK_EN
      err_pend  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef WB_SRAM_INITIATOR_ADDR_CHECK_EN
          err_pend <= 1'b0;
`endif
          if (req) begin
            if (!adr_ok) begin
`ifdef WB_SRAM_INITIATOR_ADDR_CHECK_EN
              err_pend <= 1'b1;
`endif
              state <= ACK;
            end else if (start_burst) begin
              burst_adr <= next_adr;
              state     <= BURST;
            end else begin
              state <= ACK;
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        BURST: begin
          if (!req || wb.wb_cti_i == CTI_END) begin
            state <= IDLE;
          end else if (!burst_ok) begin
            // Current beat is still acked; the following one gets the error.
`ifdef WB_SRAM_INITIATOR_ADDR_CHECK_EN
            err_pend <= 1'b1;
`endif
            state <= ACK;
          end else begin
            burst_adr <= next_adr;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    sram_oe     = 1'b0;
    sram_addr   = '0;
    sram_din    = '0;
    sram_sel    = '0;
    wb.wb_ack_o = 1'b0;
    wb.wb_err_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req && adr_ok) begin
            sram_ce   = 1'b1;
            sram_addr = wb.wb_adr_i;
            sram_we   = wb.wb_we_i;
            sram_oe   = ~wb.wb_we_i;
            sram_din  = wb.wb_dat_i;
            sram_sel  = wb.wb_we_i ? wb.wb_sel_i : {SW{1'b1}};
          end
        end
        ACK: begin
          wb.wb_ack_o = req & ~err_pend;
          wb.wb_err_o = req & err_pend;
        end
        BURST: begin
          wb.wb_ack_o = req;
          // Read ahead for the next beat unless this one is the last.
          if (req && wb.wb_cti_i != CTI_END && burst_ok) begin
            sram_ce   = 1'b1;
            sram_oe   = 1'b1;
            sram_addr = burst_adr;
            sram_sel  = {SW{1'b1}};
          end
        end
        default: begin
          sram_ce = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_sp_initiator.sv
module tb_wb_sram_sp_initiator;

  logic        clk;
  logic        rst;
  logic        sram_ce;
  logic        sram_we;
  logic        sram_oe;
  logic [31:0] sram_addr;
  logic [31:0] sram_din;
  logic [3:0]  sram_sel;
  logic [31:0] sram_dout;

  int n_cmp;
  int n_err;
  int ce_cnt;
  int we_cnt;
  logic [31:0] issue_q[$];
  logic [31:0] last_rdat;

  logic [31:0] sram_mem [0:255];
  logic [31:0] gold     [0:255];

  wb_sram_sp_initiator_if #(.AW(32), .DW(32)) bus ();

  wb_sram_sp_initiator #(.AW(32), .DW(32), .MEM_SIZE(32'h8000)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (bus),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we),
    .sram_oe   (sram_oe),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_sel  (sram_sel),
    .sram_dout (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM, one cycle read latency, aliased to 256 words.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_sel[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr[9:2]];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sram_ce) ce_cnt++;
    if (sram_ce && sram_we) we_cnt++;
    if (sram_ce && !sram_we) issue_q.push_back(sram_addr);
    if (bus.wb_ack_o || bus.wb_err_o)
      check_val("ack_err_exclusive", {63'd0, bus.wb_ack_o & bus.wb_err_o}, 64'd0);
  end

  // Expected burst address of beat k, straight from the burst rules.
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [1:0] bte, input int k);
    logic [31:0] span;
    if (bte == 2'b00) return a + 32'(4 * k);
    span = 32'd16 << (bte - 2'd1);
    return (a & ~(span - 32'd1)) | ((a + 32'(4 * k)) & (span - 32'd1));
  endfunction

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
  endtask

  // Single beat (classic, or a write tagged as burst); expects ack/err on cycle 2.
  task automatic wb_single(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti, input bit exp_err);
    int  n;
    bit  done;
    bit  got_err;
    int  ce0, we0;
    logic [31:0] rdat;
    @(posedge clk); #1;
    ce0 = ce_cnt; we0 = we_cnt;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
    bus.wb_cti_i = cti; bus.wb_bte_i = 2'b00;
    n = 0; done = 0; got_err = 0; rdat = '0;
    while (!done && n < 20) begin
      @(negedge clk); n++;
      if (bus.wb_ack_o || bus.wb_err_o) begin
        done = 1; rdat = bus.wb_dat_o; got_err = bus.wb_err_o;
      end
    end
    @(posedge clk); #1;
    bus_idle();
    check_val("single_resp_seen", {63'd0, done}, 64'd1);
    check_val("single_latency", 64'(n), 64'd2);
    check_val("single_err", {63'd0, got_err}, {63'd0, exp_err});
    check_val("single_ce_count", 64'(ce_cnt - ce0), exp_err ? 64'd0 : 64'd1);
    check_val("single_we_pulse", 64'(we_cnt - we0), (we && !exp_err) ? 64'd1 : 64'd0);
    if (!exp_err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) gold[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
      end else begin
        check_val("single_rdata", {32'd0, rdat}, {32'd0, gold[adr[9:2]]});
        last_rdat = rdat;
      end
    end
    $display("single we=%0d adr=0x%08h sel=%b cti=%b data=0x%08h err=%0d cycles=%0d",
             we, adr, sel, cti, we ? dat : rdat, got_err, n);
  endtask

  // Read burst. mode 0: full burst; 1: drop stb after stop beats; 2: rst after stop beats.
  task automatic wb_burst(input logic [31:0] adr, input logic [1:0] bte, input int nbeats,
                          input int mode, input int stop_at);
    int n, beat, first, last, stop;
    stop = (mode == 0) ? nbeats : stop_at;
    issue_q.delete();
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = adr; bus.wb_bte_i = bte; bus.wb_sel_i = 4'hF;
    bus.wb_cti_i = (nbeats == 1) ? 3'b111 : 3'b010;
    n = 0; beat = 0; first = 0; last = 0;
    while (beat < stop && n < 40) begin
      @(negedge clk); n++;
      if (bus.wb_ack_o) begin
        check_val($sformatf("burst_data_b%0d", beat), {32'd0, bus.wb_dat_o},
                  {32'd0, gold[exp_addr(adr, bte, beat) >> 2 & 32'hFF]});
        if (beat == 0) first = n;
        last = n;
        beat++;
      end
      if (mode == 2 && beat == stop) begin
        #2 rst = 1'b1;
        #1;
        check_val("rst_sram_ctl", {61'd0, sram_ce, sram_we, sram_oe}, 64'd0);
        check_val("rst_sram_bus", {sram_addr, sram_din}, 64'd0);
        check_val("rst_sram_sel", {60'd0, sram_sel}, 64'd0);
        check_val("rst_no_ack", {63'd0, bus.wb_ack_o}, 64'd0);
      end else begin
        @(posedge clk); #1;
        if (beat < nbeats) begin
          bus.wb_adr_i = exp_addr(adr, bte, beat);
          bus.wb_cti_i = (beat == nbeats - 1) ? 3'b111 : 3'b010;
        end
      end
    end
    if (mode == 1) begin
      bus.wb_stb_i = 1'b0;
      @(negedge clk);
      check_val("abort_no_ack", {63'd0, bus.wb_ack_o}, 64'd0);
      @(posedge clk); #1;
    end else if (mode == 2) begin
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      check_val("rst_hold_ack", {63'd0, bus.wb_ack_o}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end
    bus_idle();
    check_val("burst_beats", 64'(beat), 64'(stop));
    check_val("burst_first_ack", 64'(first), 64'd2);
    check_val("burst_no_gap", 64'(last), 64'(stop + 1));
    check_val("burst_issue_count_min", {63'd0, issue_q.size() >= stop}, 64'd1);
    for (int k = 0; k < stop && k < issue_q.size(); k++)
      check_val($sformatf("burst_addr_b%0d", k), {32'd0, issue_q[k]}, {32'd0, exp_addr(adr, bte, k)});
    $display("burst adr=0x%08h bte=%b beats=%0d mode=%0d acked=%0d issued=%0d",
             adr, bte, nbeats, mode, beat, issue_q.size());
  endtask

  initial begin
    logic [31:0] v;
    n_cmp = 0; n_err = 0; ce_cnt = 0; we_cnt = 0; last_rdat = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      gold[i] = v;
    end
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_sram_ctl", {61'd0, sram_ce, sram_we, sram_oe}, 64'd0);
    check_val("reset_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    check_val("reset_err", {63'd0, bus.wb_err_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    wb_single(1, 32'h10, 32'hDEADBEEF, 4'b1111, 3'b000, 0);
    wb_single(0, 32'h10, 32'h0, 4'b1111, 3'b000, 0);
    check_val("classic_readback", {32'd0, last_rdat}, 64'hDEADBEEF);
    wb_single(1, 32'h14, 32'h11223344, 4'b1111, 3'b000, 0);
    wb_single(1, 32'h14, 32'h00AA0000, 4'b0100, 3'b000, 0);
    wb_single(0, 32'h14, 32'h0, 4'b1111, 3'b000, 0);
    check_val("byte_merge", {32'd0, last_rdat}, 64'h11AA3344);
    wb_burst(32'h20, 2'b00, 4, 0, 0);
    wb_burst(32'h38, 2'b01, 4, 0, 0);
    wb_burst(32'h40, 2'b00, 8, 1, 2);
    wb_single(0, 32'h44, 32'h0, 4'b1111, 3'b000, 0);
    wb_burst(32'h80, 2'b00, 8, 2, 2);
    wb_single(0, 32'h80, 32'h0, 4'b1111, 3'b000, 0);
    wb_single(1, 32'h30, 32'hCAFEF00D, 4'b1111, 3'b010, 0);
`ifdef WB_SRAM_INITIATOR_ADDR_CHECK_EN
    wb_single(0, 32'h8000, 32'h0, 4'b1111, 3'b000, 1);
    wb_single(0, 32'h7FFC, 32'h0, 4'b1111, 3'b000, 0);
`endif

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int op;
      logic [31:0] a;
      logic [3:0]  s;
      op = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 255)) << 2;
      if (op == 0) begin
        s = 4'($urandom_range(1, 15));
        wb_single(1, a, $urandom, s, ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b000, 0);
      end else if (op == 1) begin
        wb_single(0, a, 32'h0, 4'hF, 3'b000, 0);
      end else begin
        logic [1:0] bt;
        int nb;
        bt = 2'($urandom_range(0, 3));
        nb = $urandom_range(1, 8);
        if (bt == 2'b00) a = 32'($urandom_range(0, 247)) << 2;
        wb_burst(a, bt, nb, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
